// File: rtl/yildiz_mem_io_bridge.sv
// yildiz_mem_io_bridge: CPU memory partner decoding a word RAM and an MMIO page with INPR/OUTPR byte handshakes.
module yildiz_mem_io_bridge #(
  parameter int                ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] IO_BASE   = 12'hFF0,
  parameter string             INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  input  logic              cpu_write,
  output logic [15:0]       cpu_rdata,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic [7:0]        dbg_inpr,
  output logic [7:0]        dbg_outpr
`ifdef YILDIZ_MMIO_IRQ_EN
  ,
  output logic              irq
`endif
);
  typedef enum logic {IDLE, BUSY} out_state_t;
  out_state_t state_q, state_d;
  logic [15:0] mem [0:IO_BASE-1];
  logic [15:0] rdata_q, rdata_d, status;
  logic [7:0]  inpr_q, inpr_d, outpr_q, outpr_d;
  logic        fgi_q, fgi_d, ovr_q, ovr_d, fgo;
  logic        is_ram, capture, rd_inpr, wr_status, wr_out;
  logic [ADDR_W-1:0] off;
  assign is_ram    = cpu_addr < IO_BASE;
  assign off       = cpu_addr - IO_BASE;
  assign fgo       = state_q == IDLE;
  assign capture   = in_valid && !fgi_q;
  assign rd_inpr   = !is_ram && off == 0;
  assign wr_status = cpu_write && !is_ram && off == 1;
  assign wr_out    = cpu_write && !is_ram && off == 2;
  assign status    = {13'b0, ovr_q, fgo, fgi_q};
`ifdef YILDIZ_MMIO_IRQ_EN
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_q;
  assign ctrl_d = (cpu_write && !is_ram && off == 3) ? cpu_wdata[1:0] : ctrl_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      irq_q  <= (fgi_q && ctrl_q[0]) || (fgo && ctrl_q[1] && !out_valid);
    end
  assign irq = irq_q;
`endif
  always_comb begin
    rdata_d = is_ram    ? mem[cpu_addr] :
              off == 0  ? {8'h00, inpr_q} :
              off == 1  ? status :
`ifdef YILDIZ_MMIO_IRQ_EN
              off == 3  ? {14'b0, ctrl_q} :
`endif
              16'h0000;
    inpr_d  = capture ? in_data : inpr_q;
    fgi_d   = capture ? 1'b1 : rd_inpr ? 1'b0 : fgi_q;
    ovr_d   = (wr_out && !fgo) ? 1'b1 : (wr_status && cpu_wdata[2]) ? 1'b0 : ovr_q;
    outpr_d = (wr_out && fgo) ? cpu_wdata[7:0] : outpr_q;
    state_d = fgo ? (wr_out ? BUSY : IDLE) : (out_ready ? IDLE : BUSY);
  end
  always_ff @(posedge clk)
    if (cpu_write && is_ram) mem[cpu_addr] <= cpu_wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      inpr_q  <= '0;
      outpr_q <= '0;
      fgi_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      inpr_q  <= inpr_d;
      outpr_q <= outpr_d;
      fgi_q   <= fgi_d;
      ovr_q   <= ovr_d;
    end
  assign cpu_rdata = rdata_q;
  assign in_ready  = !fgi_q;
  assign out_valid = state_q == BUSY;
  assign out_data  = outpr_q;
  assign dbg_inpr  = inpr_q;
  assign dbg_outpr = outpr_q;
endmodule

// File: tb/tb_yildiz_mem_io_bridge.sv
// tb_yildiz_mem_io_bridge: directed checks of RAM, input/output byte paths, overrun and async reset.
module tb_yildiz_mem_io_bridge;
  logic        clk = 0, rst = 0, cpu_write = 0, in_valid = 0, out_ready = 0;
  logic [11:0] cpu_addr = 0;
  logic [15:0] cpu_wdata = 0;
  logic [7:0]  in_data = 0;
  logic [15:0] cpu_rdata;
  logic        in_ready, out_valid;
  logic [7:0]  out_data, dbg_inpr, dbg_outpr;
  int total = 0, bad = 0;
`ifdef YILDIZ_MMIO_IRQ_EN
  logic irq;
`endif
  yildiz_mem_io_bridge dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .dbg_inpr(dbg_inpr), .dbg_outpr(dbg_outpr)
`ifdef YILDIZ_MMIO_IRQ_EN
    , .irq(irq)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic acc(input logic [11:0] a, input logic w, input logic [15:0] d);
    cpu_addr = a; cpu_write = w; cpu_wdata = d;
    tick();
    cpu_write = 0;
  endtask
  initial begin
    #1 rst = 1;
    #2;
    chk("rst_out_valid", {15'b0, out_valid}, 16'h0000);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_in_ready", {15'b0, in_ready}, 16'h0001);
    chk("rst_inpr_outpr", {dbg_inpr, dbg_outpr}, 16'h0000);
    tick(); tick();
    rst = 0;
    acc(12'hFF1, 0, 0);
    chk("rst_status", cpu_rdata, 16'h0002);
    // RAM write then read, read-first collision
    acc(12'h010, 1, 16'hBEEF);
    acc(12'h010, 0, 0);
    chk("ram_read", cpu_rdata, 16'hBEEF);
    acc(12'h010, 1, 16'h1234);
    chk("ram_read_first", cpu_rdata, 16'hBEEF);
    acc(12'h010, 0, 0);
    chk("ram_new_data", cpu_rdata, 16'h1234);
    acc(12'h011, 1, 16'h0F0F);
    acc(12'h011, 0, 0);
    chk("ram_other_word", cpu_rdata, 16'h0F0F);
    acc(12'h010, 0, 0);
    chk("ram_no_alias", cpu_rdata, 16'h1234);
    // input path
    in_data = 8'h5A; in_valid = 1;
    acc(12'hFF1, 0, 0);
    in_valid = 0;
    chk("in_status_pre", cpu_rdata, 16'h0002);
    chk("in_ready_low", {15'b0, in_ready}, 16'h0000);
    acc(12'hFF1, 0, 0);
    chk("in_status_fgi", cpu_rdata, 16'h0003);
    in_data = 8'h99; in_valid = 1;
    acc(12'hFF1, 0, 0);
    in_valid = 0;
    chk("in_no_capture_full", {8'h00, dbg_inpr}, 16'h005A);
    acc(12'hFF0, 0, 0);
    chk("in_read_inpr", cpu_rdata, 16'h005A);
    chk("in_ready_back", {15'b0, in_ready}, 16'h0001);
    acc(12'hFF1, 0, 0);
    chk("in_status_clr", cpu_rdata, 16'h0002);
    in_data = 8'h77; in_valid = 1;
    acc(12'hFF0, 0, 0);
    in_valid = 0;
    chk("in_race_old", cpu_rdata, 16'h005A);
    acc(12'hFF1, 0, 0);
    chk("in_race_fgi", cpu_rdata, 16'h0003);
    acc(12'hFF0, 0, 0);
    chk("in_race_new", cpu_rdata, 16'h0077);
    // unmapped I/O words
    acc(12'hFF5, 1, 16'hFFFF);
    acc(12'hFF5, 0, 0);
    chk("io_unmapped", cpu_rdata, 16'h0000);
    acc(12'hFF3, 0, 0);
    chk("io_off3_reset", cpu_rdata, 16'h0000);
    // output path
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("out_idle_ready_ignored", {15'b0, out_valid}, 16'h0000);
    acc(12'hFF2, 1, 16'h0041);
    chk("out_valid_set", {15'b0, out_valid}, 16'h0001);
    chk("out_data", {8'h00, out_data}, 16'h0041);
    chk("out_dbg", {8'h00, dbg_outpr}, 16'h0041);
    for (int i = 0; i < 5; i++) begin
      acc(12'hFF1, 0, 0);
      chk("out_hold", {out_valid, 7'b0, out_data}, 16'h8041);
      chk("out_hold_status", cpu_rdata, 16'h0000);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("out_done", {15'b0, out_valid}, 16'h0000);
    acc(12'hFF1, 0, 0);
    chk("out_fgo_back", cpu_rdata, 16'h0002);
    // overrun
    acc(12'hFF2, 1, 16'h0041);
    acc(12'hFF2, 1, 16'h0042);
    chk("ovr_data_kept", {8'h00, out_data}, 16'h0041);
    acc(12'hFF1, 0, 0);
    chk("ovr_status", cpu_rdata, 16'h0004);
    acc(12'hFF1, 1, 16'h0003);
    acc(12'hFF1, 0, 0);
    chk("ovr_sticky", cpu_rdata, 16'h0004);
    acc(12'hFF1, 1, 16'h0004);
    acc(12'hFF1, 0, 0);
    chk("ovr_cleared", cpu_rdata, 16'h0000);
    // async reset while busy
    chk("busy_before_rst", {15'b0, out_valid}, 16'h0001);
    #2 rst = 1;
    #1;
    chk("async_out_valid", {15'b0, out_valid}, 16'h0000);
    chk("async_outpr", {8'h00, dbg_outpr}, 16'h0000);
    chk("async_in_ready", {15'b0, in_ready}, 16'h0001);
    tick();
    rst = 0;
    acc(12'hFF1, 0, 0);
    chk("post_rst_status", cpu_rdata, 16'h0002);
`ifdef YILDIZ_MMIO_IRQ_EN
    chk("irq_reset", {15'b0, irq}, 16'h0000);
    acc(12'hFF3, 1, 16'h0001);
    acc(12'hFF3, 0, 0);
    chk("ctrl_read", cpu_rdata, 16'h0001);
    in_data = 8'h33; in_valid = 1;
    acc(12'hFF1, 0, 0);
    in_valid = 0;
    acc(12'hFF1, 0, 0);
    chk("irq_set", {15'b0, irq}, 16'h0001);
    acc(12'hFF0, 0, 0);
    chk("irq_read_inpr", cpu_rdata, 16'h0033);
    acc(12'hFF1, 0, 0);
    chk("irq_cleared", {15'b0, irq}, 16'h0000);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
